// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path (arbiter and uart_tx).
// Holds the arbiter FSM encoding, the default frame constants and a clog2 helper.
package uart_pkg;

    localparam int DEF_DBIT = 8;
    localparam int SB_TICK  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        GAP    = 2'd3
    } arb_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Client-side handshake bundle of uart_tx_arbiter: per-requester req/data in,
// ack/done pulses out. Clients use the master modport, the arbiter the slave modport.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DBIT = 8
);
    logic [NREQ-1:0]      req;
    logic [NREQ*DBIT-1:0] din_flat;
    logic [NREQ-1:0]      ack;
    logic [NREQ-1:0]      done;

    modport master (output req, output din_flat, input ack, input done);
    modport slave  (input req, input din_flat, output ack, output done);
endinterface

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: first set request at index >= rr_ptr_i,
// wrapping modulo NREQ.
module uart_rr_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IDW = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  rr_ptr_i,
    output logic [IDW-1:0]  gnt_id_o,
    output logic            gnt_vld_o
);

    // Scan from the farthest offset down so the nearest requester is written last.
    always_comb begin
        gnt_id_o  = '0;
        gnt_vld_o = 1'b0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            if (req_i[(int'(rr_ptr_i) + off) % NREQ]) begin
                gnt_id_o  = IDW'((int'(rr_ptr_i) + off) % NREQ);
                gnt_vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serialiser between NREQ byte producers with round-robin
// arbitration and a frame-stall watchdog. Optional post-frame gap: UART_TX_ARB_GAP_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DBIT      = DEF_DBIT,
    parameter int TMO_TICKS = 192,
    parameter int GAP_TICKS = SB_TICK
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     s_tick,
    uart_tx_arbiter_if.slave         cl,
    output logic                     tx_start,
    output logic [DBIT-1:0]          tx_din,
    input  logic                     tx_done_tick,
    output logic                     busy,
    output logic [clog2(NREQ)-1:0]   cur_id,
    output logic                     err_tmo,
    input  logic                     err_clr
);

    localparam int IDW     = clog2(NREQ);
    localparam int CNT_MAX = (TMO_TICKS > GAP_TICKS) ? TMO_TICKS : GAP_TICKS;
    localparam int TCW     = clog2(CNT_MAX) + 1;

    arb_state_e          state_q;
    logic [IDW-1:0]      rr_ptr_q;
    logic [IDW-1:0]      cur_id_q;
    logic [DBIT-1:0]     tx_din_q;
    logic [TCW-1:0]      tick_cnt_q;
    logic                tx_start_q;
    logic [NREQ-1:0]     ack_q;
    logic [NREQ-1:0]     done_q;
    logic                busy_q;
    logic                err_q;

    logic [IDW-1:0]      gnt_id_d;
    logic                gnt_vld_d;
    logic [IDW-1:0]      nxt_ptr_d;

    uart_rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req_i     (cl.req),
        .rr_ptr_i  (rr_ptr_q),
        .gnt_id_o  (gnt_id_d),
        .gnt_vld_o (gnt_vld_d)
    );

    assign nxt_ptr_d = (cur_id_q == IDW'(NREQ - 1)) ? '0 : cur_id_q + 1'b1;

    // Pulses default low each cycle; the error flag's set path follows its clear so set wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            cur_id_q   <= '0;
            tx_din_q   <= '0;
            tick_cnt_q <= '0;
            tx_start_q <= 1'b0;
            ack_q      <= '0;
            done_q     <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            ack_q      <= '0;
            done_q     <= '0;
            if (err_clr) err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt_vld_d) begin
                        cur_id_q          <= gnt_id_d;
                        tx_din_q          <= cl.din_flat[gnt_id_d*DBIT +: DBIT];
                        tx_start_q        <= 1'b1;
                        ack_q[gnt_id_d]   <= 1'b1;
                        busy_q            <= 1'b1;
                        state_q           <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    tick_cnt_q <= '0;
                    state_q    <= WAIT;
                end
                WAIT: begin
                    if (tx_done_tick) begin
                        done_q[cur_id_q] <= 1'b1;
                        rr_ptr_q         <= nxt_ptr_d;
`ifdef UART_TX_ARB_GAP_EN
                        tick_cnt_q       <= '0;
                        state_q          <= GAP;
`else
                        busy_q           <= 1'b0;
                        state_q          <= IDLE;
`endif
                    end else if (s_tick) begin
                        if (tick_cnt_q == TCW'(TMO_TICKS - 1)) begin
                            err_q    <= 1'b1;
                            rr_ptr_q <= nxt_ptr_d;
                            busy_q   <= 1'b0;
                            state_q  <= IDLE;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
                end
                GAP: begin
`ifdef UART_TX_ARB_GAP_EN
                    if (s_tick) begin
                        if (tick_cnt_q == TCW'(GAP_TICKS - 1)) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
`else
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_start = tx_start_q;
    assign tx_din   = tx_din_q;
    assign busy     = busy_q;
    assign cur_id   = cur_id_q;
    assign err_tmo  = err_q;
    assign cl.ack   = ack_q;
    assign cl.done  = done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: transaction-level reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int DBIT = 8;
    localparam int TMO  = 192;
    localparam int GAPT = 16;

    logic clk = 1'b0;
    logic reset_n;
    logic s_tick;
    logic tx_start;
    logic [DBIT-1:0] tx_din;
    logic tx_done_tick;
    logic busy;
    logic [1:0] cur_id;
    logic err_tmo;
    logic err_clr;

    uart_tx_arbiter_if #(.NREQ(NREQ), .DBIT(DBIT)) cl_if ();

    uart_tx_arbiter #(.NREQ(NREQ), .DBIT(DBIT), .TMO_TICKS(TMO), .GAP_TICKS(GAPT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_tick       (s_tick),
        .cl           (cl_if.slave),
        .tx_start     (tx_start),
        .tx_din       (tx_din),
        .tx_done_tick (tx_done_tick),
        .busy         (busy),
        .cur_id       (cur_id),
        .err_tmo      (err_tmo),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Environment knobs set by the main sequence
    bit uart_auto = 1'b1;
    int uart_dly  = 6;
    int tick_div  = 2;

    initial begin
        int tcnt;
        tcnt = 0;
        s_tick = 1'b0;
        forever begin
            @(negedge clk);
            tcnt++;
            s_tick = ((tcnt % tick_div) == 0);
        end
    end

    // Serialiser stand-in: answers tx_start with one tx_done_tick after uart_dly cycles
    initial begin
        int cd;
        cd = 0;
        tx_done_tick = 1'b0;
        forever begin
            @(negedge clk);
            tx_done_tick = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) tx_done_tick = 1'b1;
            end
            if (uart_auto && tx_start === 1'b1) cd = uart_dly;
        end
    end

    // Reference model: one frame at a time, winner by wrapped scan, tick-budgeted wait
    logic            m_start = 1'b0;
    logic [NREQ-1:0] m_ack   = '0;
    logic [NREQ-1:0] m_done  = '0;
    logic [DBIT-1:0] m_din   = '0;
    int              m_cur   = 0;
    logic            m_busy  = 1'b0;
    logic            m_err   = 1'b0;
    int              m_ptr   = 0;
    bit              m_launch = 1'b0;
    int              m_waited = 0;
    int              m_gap_left = 0;
    int              m_c;
    bit              m_found;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_start = 0; m_ack = '0; m_done = '0; m_din = '0; m_cur = 0;
            m_busy = 0; m_err = 0; m_ptr = 0; m_launch = 0; m_waited = 0; m_gap_left = 0;
        end else begin
            m_start = 0; m_ack = '0; m_done = '0;
            if (err_clr) m_err = 0;
            if (!m_busy) begin
                m_found = 0;
                for (int k = 0; k < NREQ; k++) begin
                    m_c = (m_ptr + k) % NREQ;
                    if (!m_found && cl_if.req[m_c]) begin
                        m_found = 1;
                        m_cur = m_c;
                        m_din = cl_if.din_flat[m_c*DBIT +: DBIT];
                        m_start = 1;
                        m_ack[m_c] = 1'b1;
                        m_busy = 1;
                        m_launch = 1;
                    end
                end
            end else if (m_launch) begin
                m_launch = 0;
                m_waited = 0;
            end else if (m_gap_left > 0) begin
                if (s_tick) begin
                    m_gap_left--;
                    if (m_gap_left == 0) m_busy = 0;
                end
            end else if (tx_done_tick) begin
                m_done[m_cur] = 1'b1;
                m_ptr = (m_cur + 1) % NREQ;
`ifdef UART_TX_ARB_GAP_EN
                m_gap_left = GAPT;
`else
                m_busy = 0;
`endif
            end else if (s_tick) begin
                m_waited++;
                if (m_waited == TMO) begin
                    m_err = 1;
                    m_ptr = (m_cur + 1) % NREQ;
                    m_busy = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1) begin
                chk("mdl_tx_start", tx_start, m_start);
                chk("mdl_ack", cl_if.ack, m_ack);
                chk("mdl_done", cl_if.done, m_done);
                chk("mdl_tx_din", tx_din, m_din);
                chk("mdl_busy", busy, m_busy);
                chk("mdl_cur_id", cur_id, m_cur);
                chk("mdl_err_tmo", err_tmo, m_err);
            end
        end
    end

    // Event log: ack/done counts per requester and grant order
    int ack_cnt [NREQ];
    int done_cnt[NREQ];
    int grants[$];

    initial begin
        for (int i = 0; i < NREQ; i++) begin ack_cnt[i] = 0; done_cnt[i] = 0; end
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (cl_if.ack[i] === 1'b1) begin ack_cnt[i]++; grants.push_back(i); end
                    if (cl_if.done[i] === 1'b1) done_cnt[i]++;
                end
            end
        end
    end

    task automatic wait_ack(input int id, input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (cl_if.ack[id] === 1'b1) seen = 1;
        end
        chk($sformatf("ack%0d_seen", id), seen, 1);
    endtask

    task automatic wait_done(input int id, input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (cl_if.done[id] === 1'b1) seen = 1;
        end
        chk($sformatf("done%0d_seen", id), seen, 1);
    endtask

    task automatic wait_idle(input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (busy === 1'b0) seen = 1;
        end
        chk("idle_reached", seen, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int n, a0, d0, exp_order[5];
        bit seen;
        reset_n = 1'b0;
        cl_if.req = '0;
        cl_if.din_flat = {8'h43, 8'h32, 8'h21, 8'hA5};
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_tx_start", tx_start, 0);
        chk("rst_ack_done", {cl_if.ack, cl_if.done}, 0);
        chk("rst_tx_din", tx_din, 0);
        chk("rst_busy_cur_err", {busy, cur_id, err_tmo}, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // 1: single request from requester 0
        @(negedge clk);
        cl_if.req = 4'b0001;
        @(negedge clk);
        chk("t1_tx_start", tx_start, 1);
        chk("t1_ack", cl_if.ack, 4'b0001);
        chk("t1_tx_din", tx_din, 8'hA5);
        chk("t1_busy", busy, 1);
        cl_if.req = '0;
        wait_done(0, 50);
        chk("t1_busy_after_done", busy, 0);
        repeat (3) @(negedge clk);
        chk("t1_done_count", done_cnt[0], 1);

        // 2: all four requesting, round-robin order from reset
        do_reset();
        grants.delete();
        cl_if.req = 4'b1111;
        for (int i = 0; i < 200 && grants.size() < 5; i++) @(negedge clk);
        cl_if.req = '0;
        exp_order = '{0, 1, 2, 3, 0};
        chk("t2_grant_count", (grants.size() >= 5), 1);
        for (int i = 0; i < 5; i++)
            if (i < grants.size()) chk($sformatf("t2_grant%0d", i), grants[i], exp_order[i]);
        wait_idle(50);

        // 3: one-cycle request pulse is still served exactly once
        repeat (2) @(negedge clk);
        a0 = ack_cnt[2]; d0 = done_cnt[2];
        cl_if.req = 4'b0100;
        @(negedge clk);
        cl_if.req = '0;
        chk("t3_ack", cl_if.ack, 4'b0100);
        wait_done(2, 50);
        repeat (3) @(negedge clk);
        chk("t3_ack_once", ack_cnt[2] - a0, 1);
        chk("t3_done_once", done_cnt[2] - d0, 1);

        // 4: stalled frame; err_clr held high across the timeout edge
        uart_auto = 1'b0;
        err_clr = 1'b1;
        d0 = done_cnt[1];
        cl_if.req = 4'b0010;
        wait_ack(1, 10);
        cl_if.req = '0;
        @(posedge clk);
        n = 0; seen = 0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(posedge clk);
            if (s_tick) n++;
            #1;
            if (err_tmo === 1'b1) seen = 1;
        end
        chk("t4_tmo_seen", seen, 1);
        chk("t4_tmo_ticks", n, TMO);
        chk("t4_busy_after_tmo", busy, 0);
        @(negedge clk);
        err_clr = 1'b0;
        uart_auto = 1'b1;
        cl_if.req = 4'b1000;
        wait_ack(3, 10);
        cl_if.req = '0;
        wait_done(3, 50);
        chk("t4_no_done_for_stalled", done_cnt[1] - d0, 0);
        chk("t4_err_sticky", err_tmo, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t4_err_cleared", err_tmo, 0);

        // 4b: done on the very timeout edge wins
        tick_div = 1;
        uart_dly = TMO;
        cl_if.req = 4'b0001;
        wait_ack(0, 10);
        cl_if.req = '0;
        wait_done(0, 400);
        chk("t4b_no_err", err_tmo, 0);
        tick_div = 2;
        uart_dly = 6;
        wait_idle(20);

        // 5: reset mid-WAIT abandons the frame and resets rr_ptr
        cl_if.req = 4'b0010;
        wait_ack(1, 10);
        cl_if.req = '0;
        wait_done(1, 50);
        uart_dly = 50;
        cl_if.req = 4'b0100;
        wait_ack(2, 10);
        cl_if.req = '0;
        repeat (5) @(negedge clk);
        d0 = done_cnt[2];
        #2 reset_n = 1'b0;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_tx_din", tx_din, 0);
        chk("t5_rst_misc", {tx_start, cl_if.ack, cl_if.done, cur_id, err_tmo}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        uart_dly = 6;
        repeat (60) @(negedge clk);
        chk("t5_no_done", done_cnt[2] - d0, 0);
        cl_if.req = 4'b0110;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (cl_if.ack !== 4'b0000) seen = 1;
        end
        chk("t5_first_grant", cl_if.ack, 4'b0010);
        cl_if.req = '0;
        wait_done(1, 50);
        wait_idle(20);

`ifdef UART_TX_ARB_GAP_EN
        // 6: post-frame gap delays the next launch
        do_reset();
        cl_if.req = 4'b0011;
        wait_ack(0, 10);
        cl_if.req = 4'b0010;
        wait_done(0, 50);
        n = 0; seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(posedge clk);
            if (s_tick) n++;
            #1;
            if (tx_start === 1'b1) seen = 1;
        end
        chk("t6_second_start", seen, 1);
        chk("t6_gap_ok", (n >= GAPT), 1);
        chk("t6_second_owner", cl_if.ack, 4'b0010);
        @(negedge clk);
        cl_if.req = '0;
        wait_idle(60);
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench did not finish");
    end

endmodule
